writeback_unit: RTL and testbench

Final pipeline stage of the RV32I core. It accepts retiring instructions from the memory stage and waits on the data-memory response for loads. It aligns and extends load data and drives the register-file write port that Decode consumes (`rd_Ps6`, `CtrlWriteEn`, `DataRd`). It is the producer side of the write-back interface that Decode's register file receives.

---
 rtl/writeback_unit.sv | 270 +++++++++++++++++++++++++++
 tb/tb_writeback_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// writeback_unit: final stage of the RV32I pipeline.
// Retires instructions from the memory stage. For loads it waits for the
// data-memory response, then aligns and sign/zero-extends the data. It drives
// the register-file write port that Decode consumes (rd_Ps6/CtrlWriteEn/DataRd).
//
// Optional build macro: WB_FWD_EN
//   defined   -> adds fwd_valid/fwd_rd/fwd_data, which mirror the registered
//                write port so Decode can bypass the register file.
//   undefined -> no forwarding ports and no forwarding logic.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | ready for a new instruction; any memory response is spurious
// S_WAIT_RSP | load issued, waiting for mem_rsp_valid or the timeout count

module writeback_unit #(
    parameter int XLEN         = 32,
    parameter int MSB_REG_FILE = 5,
    parameter int RSP_TIMEOUT  = 16
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [MSB_REG_FILE-1:0] in_rd,
    input  logic                    in_reg_wr,
    input  logic                    in_is_load,
    input  logic [1:0]              in_mem_size,
    input  logic                    in_unsigned,
    input  logic [1:0]              in_addr_lo,
    input  logic [XLEN-1:0]         in_result,

    input  logic                    mem_rsp_valid,
    input  logic [XLEN-1:0]         mem_rsp_data,

    output logic [MSB_REG_FILE-1:0] rd_Ps6,
    output logic                    CtrlWriteEn,
    output logic [XLEN-1:0]         DataRd,

`ifdef WB_FWD_EN
    output logic                    fwd_valid,
    output logic [MSB_REG_FILE-1:0] fwd_rd,
    output logic [XLEN-1:0]         fwd_data,
`endif

    output logic                    load_pending,
    output logic                    misalign_err,
    output logic                    timeout_err,
    output logic                    spur_rsp_err
);

    // Counter only needs to reach RSP_TIMEOUT-1.
    localparam int              CNT_W    = $clog2(RSP_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);

    // Memory access size encoding; 2'b11 behaves like a word.
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WRD2 = 2'b11;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_RSP = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;

    // Attributes of the outstanding load.
    logic [MSB_REG_FILE-1:0]   r_ld_rd;
    logic [1:0]                r_ld_size;
    logic                      r_ld_unsigned;
    logic [1:0]                r_ld_addr_lo;

    logic [CNT_W-1:0]          r_cnt;

    // Registered write port and error pulses.
    logic                      r_wr_en;
    logic [MSB_REG_FILE-1:0]   r_wr_rd;
    logic [XLEN-1:0]           r_wr_data;
    logic                      r_misalign;
    logic                      r_timeout;
    logic                      r_spur;

    // Next-cycle values decided by the FSM.
    logic                      w_wr_en_next;
    logic [MSB_REG_FILE-1:0]   w_wr_rd_next;
    logic [XLEN-1:0]           w_wr_data_next;
    logic                      w_misalign_next;
    logic                      w_timeout_next;
    logic                      w_spur_next;
    logic                      w_capture;
    logic                      w_cnt_clr;
    logic                      w_cnt_inc;

    logic                      w_misalign;
    logic                      w_cnt_done;
    logic [7:0]                w_byte;
    logic [15:0]               w_half;
    logic                      w_ext_bit;
    logic [XLEN-1:0]           w_load_value;

    // Halfwords need an even address, words need a word-aligned address.
    assign w_misalign = ((in_mem_size == SZ_HALF) && in_addr_lo[0]) ||
                        (((in_mem_size == SZ_WORD) || (in_mem_size == SZ_WRD2)) &&
                         (in_addr_lo != 2'b00));

    assign w_cnt_done = (r_cnt == CNT_LAST);

    // Lane selection works on the response word using the captured address.
    assign w_byte = 8'(mem_rsp_data >> {r_ld_addr_lo, 3'b000});
    assign w_half = 16'(mem_rsp_data >> {r_ld_addr_lo[1], 4'b0000});

    // Align and extend the returned word according to the captured load type.
    always_comb begin
        w_ext_bit    = 1'b0;
        w_load_value = mem_rsp_data;
        case (r_ld_size)
            SZ_BYTE: begin
                w_ext_bit    = w_byte[7] & ~r_ld_unsigned;
                w_load_value = {{(XLEN-8){w_ext_bit}}, w_byte};
            end
            SZ_HALF: begin
                w_ext_bit    = w_half[15] & ~r_ld_unsigned;
                w_load_value = {{(XLEN-16){w_ext_bit}}, w_half};
            end
            default: begin
                w_ext_bit    = 1'b0;
                w_load_value = mem_rsp_data;
            end
        endcase
    end

    // Next state, write-port updates and error pulses for the coming cycle.
    always_comb begin
        w_state_next    = r_state;
        w_wr_en_next    = 1'b0;
        w_wr_rd_next    = r_wr_rd;
        w_wr_data_next  = r_wr_data;
        w_misalign_next = 1'b0;
        w_timeout_next  = 1'b0;
        w_spur_next     = 1'b0;
        w_capture       = 1'b0;
        w_cnt_clr       = 1'b0;
        w_cnt_inc       = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Nothing is outstanding, so any response is unexpected.
                w_spur_next = mem_rsp_valid;
                if (in_valid) begin
                    if (in_is_load) begin
                        if (w_misalign) begin
                            w_misalign_next = 1'b1;
                        end else begin
                            w_capture    = 1'b1;
                            w_cnt_clr    = 1'b1;
                            w_state_next = S_WAIT_RSP;
                        end
                    end else if (in_reg_wr && (in_rd != '0)) begin
                        w_wr_en_next   = 1'b1;
                        w_wr_rd_next   = in_rd;
                        w_wr_data_next = in_result;
                    end
                end
            end

            S_WAIT_RSP: begin
                // A response on the final counted cycle still wins over timeout.
                if (mem_rsp_valid) begin
                    w_state_next = S_IDLE;
                    if (r_ld_rd != '0) begin
                        w_wr_en_next   = 1'b1;
                        w_wr_rd_next   = r_ld_rd;
                        w_wr_data_next = w_load_value;
                    end
                end else if (w_cnt_done) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = S_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the outstanding load's destination and formatting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ld_rd       <= '0;
            r_ld_size     <= 2'b00;
            r_ld_unsigned <= 1'b0;
            r_ld_addr_lo  <= 2'b00;
        end else if (w_capture) begin
            r_ld_rd       <= in_rd;
            r_ld_size     <= in_mem_size;
            r_ld_unsigned <= in_unsigned;
            r_ld_addr_lo  <= in_addr_lo;
        end
    end

    // Response wait counter, cleared when a load starts waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Registered write port; address and data hold while no write occurs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_rd   <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en   <= w_wr_en_next;
            r_wr_rd   <= w_wr_rd_next;
            r_wr_data <= w_wr_data_next;
        end
    end

    // Registered one-cycle error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
            r_spur     <= 1'b0;
        end else begin
            r_misalign <= w_misalign_next;
            r_timeout  <= w_timeout_next;
            r_spur     <= w_spur_next;
        end
    end

    assign in_ready     = (r_state == S_IDLE);
    assign load_pending = (r_state == S_WAIT_RSP);
    assign rd_Ps6       = r_wr_rd;
    assign CtrlWriteEn  = r_wr_en;
    assign DataRd       = r_wr_data;
    assign misalign_err = r_misalign;
    assign timeout_err  = r_timeout;
    assign spur_rsp_err = r_spur;

`ifdef WB_FWD_EN
    // Bypass copy of the value being written this cycle.
    assign fwd_valid = r_wr_en;
    assign fwd_rd    = r_wr_rd;
    assign fwd_data  = r_wr_data;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int TO   = 16;
    localparam int N    = 1024;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready, in_reg_wr, in_is_load, in_unsigned;
    logic [RW-1:0]   in_rd;
    logic [1:0]      in_mem_size, in_addr_lo;
    logic [XLEN-1:0] in_result;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;
    logic [RW-1:0]   rd_Ps6;
    logic            CtrlWriteEn;
    logic [XLEN-1:0] DataRd;
    logic            load_pending, misalign_err, timeout_err, spur_rsp_err;
`ifdef WB_FWD_EN
    logic            fwd_valid;
    logic [RW-1:0]   fwd_rd;
    logic [XLEN-1:0] fwd_data;
`endif

    always #5 clk = ~clk;

    writeback_unit #(.XLEN(XLEN), .MSB_REG_FILE(RW), .RSP_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
        .in_reg_wr(in_reg_wr), .in_is_load(in_is_load),
        .in_mem_size(in_mem_size), .in_unsigned(in_unsigned),
        .in_addr_lo(in_addr_lo), .in_result(in_result),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .rd_Ps6(rd_Ps6), .CtrlWriteEn(CtrlWriteEn), .DataRd(DataRd),
`ifdef WB_FWD_EN
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
        .load_pending(load_pending), .misalign_err(misalign_err),
        .timeout_err(timeout_err), .spur_rsp_err(spur_rsp_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Per-cycle expectations, indexed by the clock edge after which they hold.
    bit          e_we   [N];
    bit [RW-1:0] e_rd   [N];
    bit [31:0]   e_data [N];
    bit          e_mis  [N];
    bit          e_to   [N];
    bit          e_spur [N];
    bit          e_busy [N];
    bit          e_rst  [N];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Expected register value of a load, from the byte lanes of the word.
    function automatic bit [31:0] m_load(input bit [31:0] w, input bit [1:0] sz,
                                         input bit uns, input bit [1:0] alo);
        bit [7:0]  b [4];
        bit [15:0] h;
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        if (sz == 2'b01) begin
            return uns ? {24'h0, b[alo]} : {{24{b[alo][7]}}, b[alo]};
        end else if (sz == 2'b10) begin
            h = {b[int'(alo) + 1], b[alo]};
            return uns ? {16'h0, h} : {{16{h[15]}}, h};
        end
        return w;
    endfunction

    function automatic bit m_misaligned(input bit [1:0] sz, input bit [1:0] alo);
        if (sz == 2'b01) return 1'b0;
        if (sz == 2'b10) return alo[0];
        return alo != 2'b00;
    endfunction

    // Compare process: every output, every cycle, against the expectations.
    initial begin : cmp
        bit [RW-1:0] h_rd;
        bit [31:0]   h_data;
        h_rd   = '0;
        h_data = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc < N) begin
                if (e_rst[cyc]) begin
                    h_rd   = '0;
                    h_data = '0;
                end else if (e_we[cyc]) begin
                    h_rd   = e_rd[cyc];
                    h_data = e_data[cyc];
                end
                chk("we",      32'(CtrlWriteEn),  32'(e_we[cyc]));
                chk("rd",      32'(rd_Ps6),       32'(h_rd));
                chk("data",    DataRd,            h_data);
                chk("mis",     32'(misalign_err), 32'(e_mis[cyc]));
                chk("tmo",     32'(timeout_err),  32'(e_to[cyc]));
                chk("spur",    32'(spur_rsp_err), 32'(e_spur[cyc]));
                chk("ready",   32'(in_ready),     32'(!e_busy[cyc]));
                chk("pending", 32'(load_pending), 32'(e_busy[cyc]));
`ifdef WB_FWD_EN
                chk("fwd_v",   32'(fwd_valid),    32'(e_we[cyc]));
                chk("fwd_rd",  32'(fwd_rd),       32'(h_rd));
                chk("fwd_d",   fwd_data,          h_data);
`endif
            end
        end
    end

    task automatic clear_in();
        in_valid      = 1'b0;
        in_is_load    = 1'b0;
        in_reg_wr     = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h5A5A_5A5A;
    endtask

    task automatic alu(input bit [RW-1:0] rd, input bit wr, input bit [31:0] res);
        int k;
        @(negedge clk);
        clear_in();
        in_valid   = 1'b1;
        in_rd      = rd;
        in_reg_wr  = wr;
        in_result  = res;
        k          = cyc + 1;
        e_we[k]    = wr && (rd != 0);
        e_rd[k]    = rd;
        e_data[k]  = res;
    endtask

    // d = edge offset of the response after acceptance; d > TO means none.
    task automatic ld(input bit [RW-1:0] rd, input bit [1:0] sz, input bit uns,
                      input bit [1:0] alo, input int d, input bit [31:0] w);
        int k, r;
        @(negedge clk);
        clear_in();
        in_valid    = 1'b1;
        in_is_load  = 1'b1;
        in_reg_wr   = 1'b1;
        in_rd       = rd;
        in_mem_size = sz;
        in_unsigned = uns;
        in_addr_lo  = alo;
        in_result   = 32'hBAD0_BAD0;
        k = cyc + 1;
        if (m_misaligned(sz, alo)) begin
            e_mis[k] = 1'b1;
            return;
        end
        if (d > TO) begin
            r = k + TO;
            for (int i = k; i < r; i++) e_busy[i] = 1'b1;
            e_to[r] = 1'b1;
            do begin
                @(negedge clk);
                clear_in();
            end while (cyc + 1 < r);
        end else begin
            r = k + d;
            for (int i = k; i < r; i++) e_busy[i] = 1'b1;
            e_we[r]   = (rd != 0);
            e_rd[r]   = rd;
            e_data[r] = m_load(w, sz, uns, alo);
            do begin
                @(negedge clk);
                clear_in();
            end while (cyc + 1 < r);
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = w;
        end
    endtask

    task automatic spur(input bit [31:0] w);
        @(negedge clk);
        clear_in();
        mem_rsp_valid   = 1'b1;
        mem_rsp_data    = w;
        e_spur[cyc + 1] = 1'b1;
    endtask

    initial begin : drv
        int k;
        rst = 1'b1;
        clear_in();
        in_rd = '0; in_mem_size = 2'b00; in_unsigned = 1'b0;
        in_addr_lo = 2'b00; in_result = '0;
        e_rst[1] = 1'b1;
        e_rst[2] = 1'b1;

        // Pin the load model to hand-computed values.
        chk("model_lb",  m_load(32'h0080_0000, 2'b01, 1'b0, 2'd2), 32'hFFFF_FF80);
        chk("model_lbu", m_load(32'h0080_0000, 2'b01, 1'b1, 2'd2), 32'h0000_0080);
        chk("model_lh",  m_load(32'h8001_0000, 2'b10, 1'b0, 2'd2), 32'hFFFF_8001);
        chk("model_lhu", m_load(32'h1234_F00F, 2'b10, 1'b1, 2'd0), 32'h0000_F00F);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ADD-style result, then literal checks on the write and its length.
        alu(5'd5, 1'b1, 32'h0000_1234);
        @(negedge clk);
        clear_in();
        chk("lit_add_we",   32'(CtrlWriteEn), 32'd1);
        chk("lit_add_rd",   32'(rd_Ps6),      32'd5);
        chk("lit_add_data", DataRd,           32'h0000_1234);
        @(negedge clk);
        chk("lit_add_once", 32'(CtrlWriteEn), 32'd0);

        // Back-to-back non-loads, including no-write and x0 cases.
        alu(5'd1,  1'b1, 32'h1111_0001);
        alu(5'd2,  1'b1, 32'h2222_0002);
        alu(5'd31, 1'b1, 32'hFFFF_FFFF);
        alu(5'd7,  1'b0, 32'h7777_7777);
        alu(5'd0,  1'b1, 32'hDEAD_BEEF);

        // LB at lane 2, write one cycle after the response.
        ld(5'd4, 2'b01, 1'b0, 2'd2, 3, 32'h0080_0000);
        @(negedge clk);
        clear_in();
        chk("lit_lb", DataRd, 32'hFFFF_FF80);

        // LBU, then an immediate non-load in the write cycle.
        ld(5'd6, 2'b01, 1'b1, 2'd2, 1, 32'h0080_0000);
        alu(5'd8, 1'b1, 32'h0000_0808);

        // Misaligned loads.
        ld(5'd9,  2'b10, 1'b0, 2'd1, 2, 32'h0);
        ld(5'd9,  2'b00, 1'b0, 2'd2, 2, 32'h0);
        ld(5'd9,  2'b11, 1'b0, 2'd3, 2, 32'h0);

        // Aligned halves, words and the remaining byte lanes.
        ld(5'd10, 2'b10, 1'b0, 2'd2, 2, 32'h8001_0000);
        ld(5'd11, 2'b10, 1'b1, 2'd0, 4, 32'h1234_F00F);
        ld(5'd12, 2'b00, 1'b0, 2'd0, 1, 32'hCAFE_F00D);
        ld(5'd13, 2'b11, 1'b0, 2'd0, 2, 32'h8765_4321);
        ld(5'd14, 2'b01, 1'b0, 2'd0, 1, 32'h1122_337F);
        ld(5'd15, 2'b01, 1'b0, 2'd1, 1, 32'h1122_9F44);
        ld(5'd16, 2'b01, 1'b1, 2'd3, 1, 32'hF122_3344);
        ld(5'd17, 2'b10, 1'b0, 2'd0, 1, 32'h0000_7FFF);

        // Timeout, then a late response is spurious.
        ld(5'd18, 2'b00, 1'b0, 2'd0, 99, 32'h0);
        @(negedge clk);
        clear_in();
        chk("lit_tmo", 32'(timeout_err), 32'd1);
        spur(32'h1357_9BDF);

        // Load to x0 waits for its response but does not write.
        ld(5'd0, 2'b00, 1'b0, 2'd0, 3, 32'h0BAD_0BAD);

        // Reset in the middle of a wait.
        alu(5'd20, 1'b1, 32'h0000_CAFE);
        @(negedge clk);
        clear_in();
        in_valid = 1'b1; in_is_load = 1'b1; in_reg_wr = 1'b1;
        in_rd = 5'd21; in_mem_size = 2'b00; in_addr_lo = 2'd0;
        k = cyc + 1;
        for (int i = 0; i < 4; i++) e_busy[k + i] = 1'b1;
        e_rst[k + 4] = 1'b1;
        e_rst[k + 5] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            clear_in();
        end
        rst = 1'b1;
        #1;
        chk("rst_ready", 32'(in_ready),     32'd1);
        chk("rst_pend",  32'(load_pending), 32'd0);
        chk("rst_data",  DataRd,            32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        spur(32'h2468_ACE0);

        // Response on the last counted cycle beats the timeout.
        ld(5'd22, 2'b00, 1'b0, 2'd0, TO, 32'h600D_600D);
        alu(5'd23, 1'b1, 32'h0000_0023);

        repeat (3) begin
            @(negedge clk);
            clear_in();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
